remote_comm: RTL and testbench



---
 rtl/remote_comm.sv | 145 ++++++++++++++
 tb/tb_remote_comm.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/remote_comm.sv
// Host-side command framer: sends opcode, data[15:8], data[7:0] through a byte UART,
// then waits for one response byte or gives up after TIMEOUT_CYC cycles.
module remote_comm #(
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        snd_cmd,
  input  logic [7:0]  cmd,
  input  logic [15:0] data,
  input  logic        clr_resp_rdy,
  output logic        busy,
  output logic        cmd_sent,
  output logic [7:0]  resp,
  output logic        resp_rdy,
  output logic        timeout,
  output logic [7:0]  tx_data,
  output logic        trmt,
  input  logic        tx_done,
  input  logic [7:0]  rx_data,
  input  logic        rx_rdy,
  output logic        clr_rx_rdy,
  output logic [2:0]  state_dbg
);

  localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    TX_CMD    = 3'd1,
    TX_HI     = 3'd2,
    TX_LO     = 3'd3,
    WAIT_RESP = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [15:0]   data_sh_q, data_sh_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          trmt_q, trmt_d;
  logic          cmd_sent_q, cmd_sent_d;
  logic [7:0]    resp_q, resp_d;
  logic          resp_rdy_q, resp_rdy_d;
  logic          timeout_q, timeout_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          byte_done;

  // tx_done is still high from the previous byte while trmt is out, so it is ignored then.
  assign byte_done = tx_done & ~trmt_q;

  always_comb begin
    state_d    = state_q;
    data_sh_d  = data_sh_q;
    tx_data_d  = tx_data_q;
    trmt_d     = 1'b0;
    cmd_sent_d = 1'b0;
    resp_d     = resp_q;
    resp_rdy_d = resp_rdy_q & ~clr_resp_rdy;
    timeout_d  = timeout_q;
    cnt_d      = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (snd_cmd) begin
          // tx_data_q holds the opcode for the whole TX_CMD phase, so it doubles as its shadow.
          data_sh_d  = data;
          tx_data_d  = cmd;
          trmt_d     = 1'b1;
          resp_rdy_d = 1'b0;
          timeout_d  = 1'b0;
          state_d    = TX_CMD;
        end
      end
      TX_CMD: begin
        if (byte_done) begin
          tx_data_d = data_sh_q[15:8];
          trmt_d    = 1'b1;
          state_d   = TX_HI;
        end
      end
      TX_HI: begin
        if (byte_done) begin
          tx_data_d = data_sh_q[7:0];
          trmt_d    = 1'b1;
          state_d   = TX_LO;
        end
      end
      TX_LO: begin
        if (byte_done) begin
          cmd_sent_d = 1'b1;
          cnt_d      = '0;
          state_d    = WAIT_RESP;
        end
      end
      WAIT_RESP: begin
        cnt_d = cnt_q + 1'b1;
        // A response arriving on the last allowed cycle still counts.
        if (rx_rdy) begin
          resp_d     = rx_data;
          resp_rdy_d = 1'b1;
          state_d    = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      data_sh_q  <= '0;
      tx_data_q  <= '0;
      trmt_q     <= 1'b0;
      cmd_sent_q <= 1'b0;
      resp_q     <= '0;
      resp_rdy_q <= 1'b0;
      timeout_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      data_sh_q  <= data_sh_d;
      tx_data_q  <= tx_data_d;
      trmt_q     <= trmt_d;
      cmd_sent_q <= cmd_sent_d;
      resp_q     <= resp_d;
      resp_rdy_q <= resp_rdy_d;
      timeout_q  <= timeout_d;
      cnt_q      <= cnt_d;
    end
  end

  // Received bytes are always acknowledged: captured in WAIT_RESP, dropped elsewhere.
  assign clr_rx_rdy = rx_rdy;
  assign busy       = (state_q != IDLE);
  assign cmd_sent   = cmd_sent_q;
  assign resp       = resp_q;
  assign resp_rdy   = resp_rdy_q;
  assign timeout    = timeout_q;
  assign tx_data    = tx_data_q;
  assign trmt       = trmt_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_remote_comm.sv
// Bench for remote_comm: UART model with a byte scoreboard, plus one task per scenario.
module tb_remote_comm;
  localparam int TCYC = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        snd_cmd;
  logic [7:0]  cmd;
  logic [15:0] data;
  logic        clr_resp_rdy;
  logic        busy, cmd_sent, resp_rdy, timeout, trmt, clr_rx_rdy;
  logic [7:0]  resp, tx_data;
  logic        tx_done;
  logic [7:0]  rx_data;
  logic        rx_rdy;
  logic [2:0]  state_dbg;

  int checks = 0;
  int failures = 0;
  int trmt_cnt = 0;
  int cs_cnt = 0;
  int cd = 0;
  logic clr_pend = 1'b0;
  logic [7:0] exp_q[$];

  remote_comm #(.TIMEOUT_CYC(TCYC)) dut (
    .clk(clk), .rst(rst), .snd_cmd(snd_cmd), .cmd(cmd), .data(data),
    .clr_resp_rdy(clr_resp_rdy), .busy(busy), .cmd_sent(cmd_sent), .resp(resp),
    .resp_rdy(resp_rdy), .timeout(timeout), .tx_data(tx_data), .trmt(trmt),
    .tx_done(tx_done), .rx_data(rx_data), .rx_rdy(rx_rdy), .clr_rx_rdy(clr_rx_rdy),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // UART model: tx_done drops the cycle after trmt and rises 10 cycles later.
  always @(negedge clk) begin
    if (trmt) begin
      logic [7:0] e;
      trmt_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL tx_byte unexpected trmt got=%h", tx_data);
      end else begin
        e = exp_q.pop_front();
        if (tx_data !== e) begin
          failures++;
          $display("FAIL tx_byte got=%h exp=%h", tx_data, e);
        end
      end
      clr_pend = 1'b1;
      cd = 10;
    end else begin
      if (clr_pend) begin
        tx_done = 1'b0;
        clr_pend = 1'b0;
      end
      if (cd > 0) begin
        cd--;
        if (cd == 0) tx_done = 1'b1;
      end
    end
    if (cmd_sent) cs_cnt++;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [15:0] d);
    snd_cmd = 1'b1;
    cmd = c;
    data = d;
    exp_q.push_back(c);
    exp_q.push_back(d[15:8]);
    exp_q.push_back(d[7:0]);
    tick();
    snd_cmd = 1'b0;
    checks++;
    if (busy !== 1'b1 || trmt !== 1'b1) begin
      failures++;
      $display("FAIL accept busy=%b trmt=%b exp=1,1", busy, trmt);
    end
  endtask

  task automatic wait_cmd_sent();
    int n = 0;
    while (cmd_sent !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    checks++;
    if (cmd_sent !== 1'b1) begin
      failures++;
      $display("FAIL cmd_sent_wait got=%b exp=1 within 300 cycles", cmd_sent);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    if ({busy, cmd_sent, resp_rdy, timeout, trmt, tx_data, resp} !== 21'd0) begin
      failures++;
      $display("FAIL reset_state got busy=%b cs=%b rr=%b to=%b trmt=%b tx=%h resp=%h exp all 0",
               busy, cmd_sent, resp_rdy, timeout, trmt, tx_data, resp);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_frame_order();
    int t0 = trmt_cnt;
    int c0 = cs_cnt;
    send_frame(8'h05, 16'hA55A);
    wait_cmd_sent();
    tick();
    checks++;
    if (trmt_cnt - t0 != 3 || cs_cnt - c0 != 1 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL frame_order trmt=%0d cmd_sent=%0d left=%0d exp 3,1,0",
               trmt_cnt - t0, cs_cnt - c0, exp_q.size());
    end
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL wait_busy got=%b exp=1", busy);
    end
  endtask

  task automatic test_response();
    rx_data = 8'hA5;
    rx_rdy = 1'b1;
    #1;
    checks++;
    if (clr_rx_rdy !== 1'b1) begin
      failures++;
      $display("FAIL resp_clr_rx got=%b exp=1", clr_rx_rdy);
    end
    tick();
    rx_rdy = 1'b0;
    checks++;
    if (resp !== 8'hA5 || resp_rdy !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL resp_capture resp=%h rr=%b busy=%b exp A5,1,0", resp, resp_rdy, busy);
    end
    clr_resp_rdy = 1'b1;
    tick();
    clr_resp_rdy = 1'b0;
    checks++;
    if (resp_rdy !== 1'b0 || resp !== 8'hA5) begin
      failures++;
      $display("FAIL resp_clear rr=%b resp=%h exp 0,A5", resp_rdy, resp);
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    send_frame(8'h21, 16'h0102);
    wait_cmd_sent();
    while (timeout !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (n != TCYC) begin
      failures++;
      $display("FAIL timeout_latency got=%0d exp=%0d cycles after cmd_sent", n, TCYC);
    end
    checks++;
    if (timeout !== 1'b1 || resp_rdy !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL timeout_state to=%b rr=%b busy=%b exp 1,0,0", timeout, resp_rdy, busy);
    end
    send_frame(8'h22, 16'h0304);
    checks++;
    if (timeout !== 1'b0) begin
      failures++;
      $display("FAIL timeout_clear got=%b exp=0", timeout);
    end
    wait_cmd_sent();
    rx_data = 8'h11;
    rx_rdy = 1'b1;
    tick();
    rx_rdy = 1'b0;
    checks++;
    if (resp !== 8'h11 || resp_rdy !== 1'b1) begin
      failures++;
      $display("FAIL timeout_next_resp resp=%h rr=%b exp 11,1", resp, resp_rdy);
    end
  endtask

  task automatic test_boundary();
    send_frame(8'h30, 16'hBEEF);
    wait_cmd_sent();
    repeat (TCYC - 1) tick();
    rx_data = 8'h3C;
    rx_rdy = 1'b1;
    tick();
    rx_rdy = 1'b0;
    checks++;
    if (resp !== 8'h3C || resp_rdy !== 1'b1 || timeout !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL boundary resp=%h rr=%b to=%b busy=%b exp 3C,1,0,0",
               resp, resp_rdy, timeout, busy);
    end
  endtask

  task automatic test_robust();
    int t0 = trmt_cnt;
    int n = 0;
    send_frame(8'h12, 16'h3456);
    rx_data = 8'hEE;
    rx_rdy = 1'b1;
    cmd = 8'hFF;
    data = 16'hFFFF;
    #1;
    checks++;
    if (clr_rx_rdy !== 1'b1) begin
      failures++;
      $display("FAIL flush_clr got=%b exp=1", clr_rx_rdy);
    end
    tick();
    rx_rdy = 1'b0;
    while (trmt_cnt - t0 < 2 && n < 100) begin
      tick();
      n++;
    end
    repeat (3) tick();
    snd_cmd = 1'b1;
    cmd = 8'h99;
    data = 16'h9999;
    tick();
    snd_cmd = 1'b0;
    wait_cmd_sent();
    tick();
    checks++;
    if (trmt_cnt - t0 != 3 || resp !== 8'h3C || exp_q.size() != 0) begin
      failures++;
      $display("FAIL robust trmt=%0d resp=%h left=%0d exp 3,3C,0", trmt_cnt - t0, resp, exp_q.size());
    end
    rx_data = 8'h77;
    rx_rdy = 1'b1;
    tick();
    rx_rdy = 1'b0;
    checks++;
    if (resp !== 8'h77 || resp_rdy !== 1'b1) begin
      failures++;
      $display("FAIL robust_resp resp=%h rr=%b exp 77,1", resp, resp_rdy);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 2; i++) begin
      logic [7:0]  c = 8'($urandom_range(0, 255));
      logic [15:0] d = 16'($urandom_range(0, 65535));
      logic [7:0]  r = 8'($urandom_range(0, 255));
      send_frame(c, d);
      wait_cmd_sent();
      repeat (2) tick();
      rx_data = r;
      rx_rdy = 1'b1;
      tick();
      rx_rdy = 1'b0;
      checks++;
      if (resp !== r || resp_rdy !== 1'b1 || busy !== 1'b0 || exp_q.size() != 0) begin
        failures++;
        $display("FAIL b2b_%0d resp=%h rr=%b busy=%b exp %h,1,0", i, resp, resp_rdy, busy, r);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int t0 = trmt_cnt;
    int n = 0;
    send_frame(8'h44, 16'h5566);
    while (trmt_cnt - t0 < 2 && n < 100) begin
      tick();
      n++;
    end
    repeat (2) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({busy, cmd_sent, resp_rdy, timeout, trmt, tx_data, resp} !== 21'd0) begin
      failures++;
      $display("FAIL reset_mid got busy=%b cs=%b rr=%b to=%b trmt=%b tx=%h resp=%h exp all 0",
               busy, cmd_sent, resp_rdy, timeout, trmt, tx_data, resp);
    end
    exp_q.delete();
    t0 = trmt_cnt;
    repeat (30) tick();
    checks++;
    if (trmt_cnt != t0) begin
      failures++;
      $display("FAIL reset_no_trmt got=%0d extra exp=0", trmt_cnt - t0);
    end
    send_frame(8'hC3, 16'h1234);
    wait_cmd_sent();
    rx_data = 8'h5A;
    rx_rdy = 1'b1;
    tick();
    rx_rdy = 1'b0;
    checks++;
    if (resp !== 8'h5A || resp_rdy !== 1'b1 || exp_q.size() != 0 || trmt_cnt - t0 != 3) begin
      failures++;
      $display("FAIL reset_fresh resp=%h rr=%b left=%0d trmt=%0d exp 5A,1,0,3",
               resp, resp_rdy, exp_q.size(), trmt_cnt - t0);
    end
  endtask

  initial begin
    rst = 1'b1;
    snd_cmd = 1'b0;
    cmd = '0;
    data = '0;
    clr_resp_rdy = 1'b0;
    tx_done = 1'b0;
    rx_data = '0;
    rx_rdy = 1'b0;
    test_reset();
    test_frame_order();
    test_response();
    test_timeout();
    test_boundary();
    test_robust();
    test_back_to_back();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
